// File: rtl/noc_out_sched_pkg.sv
// rtl/noc_out_sched_pkg.sv - shared noc parameters for the output-port scheduler
//
// Purpose: flit-type width and encodings, scheduler state type and the
//          credit-counter width helper shared by the noc_out_sched files.
// Ports:   none (package).
package noc_out_sched_pkg;

  localparam int FTYPEWD = 2;

  localparam logic [FTYPEWD-1:0] ENC_PAYL = 2'b00;
  localparam logic [FTYPEWD-1:0] ENC_HEAD = 2'b01;
  localparam logic [FTYPEWD-1:0] ENC_TAIL = 2'b10;
  localparam logic [FTYPEWD-1:0] ENC_SING = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Bits needed to hold every value 0..credits inclusive.
  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/noc_out_sched_if.sv
// rtl/noc_out_sched_if.sv - request/grant bundle between inputs and one output scheduler
//
// Purpose: groups the per-input request lines, downstream credit return and
//          scheduler outputs of one switch output port.
// Ports (signals):
//   req_valid[N_IN], req_ftype[N_IN*FTYPEWD], req_match[N_IN], credit_in  : master -> slave
//   sel[N_IN], ack[N_IN], valid_out, shift_ctl, credits[CNT_W], locked    : slave -> master
// Modports: master (input ports / downstream side), slave (the scheduler).
interface noc_out_sched_if #(
  parameter int N_IN    = 6,
  parameter int FTYPEWD = noc_out_sched_pkg::FTYPEWD,
  parameter int CNT_W   = 3
);

  logic [N_IN-1:0]         req_valid;
  logic [N_IN*FTYPEWD-1:0] req_ftype;
  logic [N_IN-1:0]         req_match;
  logic                    credit_in;
  logic [N_IN-1:0]         sel;
  logic [N_IN-1:0]         ack;
  logic                    valid_out;
  logic                    shift_ctl;
  logic [CNT_W-1:0]        credits;
  logic                    locked;

  modport master (
    output req_valid, req_ftype, req_match, credit_in,
    input  sel, ack, valid_out, shift_ctl, credits, locked
  );

  modport slave (
    input  req_valid, req_ftype, req_match, credit_in,
    output sel, ack, valid_out, shift_ctl, credits, locked
  );

endinterface

// File: rtl/noc_rr_arbiter.sv
// rtl/noc_rr_arbiter.sv - combinational N-way pick starting at a one-hot pointer
//
// Purpose: grants the first requester found searching upward from the pointer
//          position, wrapping from N-1 to 0. A constant pointer of bit 0
//          turns it into a lowest-index-wins fixed-priority arbiter.
// Ports:
//   req_i [N] in  : request vector
//   ptr_i [N] in  : one-hot search start position
//   gnt_o [N] out : one-hot grant, all-zero when nothing requests
module noc_rr_arbiter #(
  parameter int N = 6
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] ptr_i,
  output logic [N-1:0] gnt_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] start;
  logic [IW-1:0] idx;
  logic          found;
  int            pos;

  always_comb begin
    start = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr_i[i]) start = IW'(i);
    end

    gnt_o = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      idx = IW'(pos);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_out_sched.sv
// rtl/noc_out_sched.sv - per-output-port wormhole scheduler with credit flow control
//
// Purpose: picks which input drives this switch output, holds the output for
//          a whole packet, and tracks downstream buffer space with credits.
// Build option: NOC_RROBIN_ARB_EN defined -> round-robin among head/single
//          flits; undefined -> fixed priority, lowest input index wins.
// Ports:
//   clk  in : switch clock
//   rst  in : asynchronous active-high reset
//   bus     : noc_out_sched_if.slave (requests, credit return, sel/ack/valid_out,
//             shift_ctl, credits, locked)
module noc_out_sched #(
  parameter int N_IN    = 6,
  parameter int FTYPEWD = noc_out_sched_pkg::FTYPEWD,
  parameter int CREDITS = 4,
  parameter int CNT_W   = noc_out_sched_pkg::credit_width(CREDITS)
) (
  input logic            clk,
  input logic            rst,
  noc_out_sched_if.slave bus
);

  import noc_out_sched_pkg::*;

  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  state_e             state_q, state_d;
  logic [N_IN-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]   cred_q, cred_d;
  logic [N_IN-1:0]    arb_ptr;
  logic [N_IN-1:0]    cand;
  logic [N_IN-1:0]    gnt;
  logic [N_IN-1:0]    sel_c;
  logic               vout_c;
  logic               xfer;
  logic [FTYPEWD-1:0] cur_ft;

  // Only packet starters may compete for an idle output; stray payload or
  // tail flits are left waiting upstream.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (bus.req_valid[i] && bus.req_match[i] &&
          (bus.req_ftype[i*FTYPEWD +: FTYPEWD] == ENC_HEAD ||
           bus.req_ftype[i*FTYPEWD +: FTYPEWD] == ENC_SING)) begin
        cand[i] = 1'b1;
      end
    end
  end

  noc_rr_arbiter #(.N(N_IN)) u_arb (
    .req_i (cand),
    .ptr_i (arb_ptr),
    .gnt_o (gnt)
  );

  // Output selection; a transfer additionally needs a free downstream slot.
  always_comb begin
    sel_c  = '0;
    vout_c = 1'b0;
    if (state_q == ST_IDLE) begin
      sel_c  = gnt;
      vout_c = |cand;
    end else begin
      sel_c  = owner_q;
      vout_c = |(bus.req_valid & owner_q);
    end

    cur_ft = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel_c[i]) cur_ft = bus.req_ftype[i*FTYPEWD +: FTYPEWD];
    end

    xfer = vout_c && (cred_q != '0) && !rst;
  end

`ifdef NOC_RROBIN_ARB_EN
  logic [N_IN-1:0] ptr_q, ptr_d;

  // Pointer moves past the winner only when a packet actually starts, so a
  // grant lost to zero credits is retried from the same position.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && state_q == ST_IDLE) begin
      ptr_d = '0;
      for (int i = 0; i < N_IN; i++) begin
        ptr_d[(i + 1) % N_IN] = sel_c[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= N_IN'(1);
    else     ptr_q <= ptr_d;
  end

  assign arb_ptr = ptr_q;
`else
  assign arb_ptr = N_IN'(1);
`endif

  // Lock FSM: a head opens the wormhole, tail or single closes it.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer && cur_ft == ENC_HEAD) begin
          state_d = ST_LOCKED;
          owner_d = sel_c;
        end
      end
      ST_LOCKED: begin
        if (xfer && (cur_ft == ENC_TAIL || cur_ft == ENC_SING)) begin
          state_d = ST_IDLE;
          owner_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = '0;
      end
    endcase
  end

  // Credit counter; a return at full count is dropped rather than wrapping.
  always_comb begin
    cred_d = cred_q;
    if (xfer && !bus.credit_in) begin
      cred_d = cred_q - CNT_W'(1);
    end else if (!xfer && bus.credit_in && cred_q != CRED_MAX) begin
      cred_d = cred_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      cred_q  <= CRED_MAX;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cred_q  <= cred_d;
    end
  end

  assign bus.sel       = rst ? '0 : sel_c;
  assign bus.valid_out = vout_c && !rst;
  assign bus.ack       = xfer ? sel_c : '0;
  assign bus.shift_ctl = xfer && (state_q == ST_IDLE);
  assign bus.credits   = cred_q;
  assign bus.locked    = (state_q == ST_LOCKED);

endmodule

// File: doc/noc_out_sched.md
# noc_out_sched

Per-output-port scheduler for the xpipes-style NoC switch. Each instance owns one switch output port and decides which input port may drive it on each cycle. Arbitration among head/single flits is round-robin, and the chosen input keeps the output for its whole wormhole packet. Downstream buffer space is tracked with a credit counter, so the block needs no busy signal from the downstream side. It drives the crossbar mux select, the per-input accept lines and the path-shift control.

## Interface
Parameters:
- N_IN, default 6: number of input ports competing for this output.
- FTYPEWD, default 2: flit-type field width.
- CREDITS, default 4: downstream buffer depth in flits.
- CNT_W, default $clog2(CREDITS+1): credit counter width (derived).

Ports:
- clk  in  1  switch clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_IN  flit present on input i.
- req_ftype  in  N_IN*FTYPEWD  flit type of input i, slice i = [i*FTYPEWD +: FTYPEWD].
- req_match  in  N_IN  route field of input i targets this output.
- credit_in  in  1  downstream freed one buffer slot.
- sel  out  N_IN  one-hot crossbar select, or all-zero.
- ack  out  N_IN  flit on input i transferred this cycle.
- valid_out  out  1  a flit is driven to the output this cycle.
- shift_ctl  out  1  the transferred flit is a head or single, so trim one path field.
- credits  out  CNT_W  current credit count.
- locked  out  1  a packet currently holds the output.

## Operation
- Flit-type encodings are ENC_HEAD, ENC_PAYL, ENC_TAIL and ENC_SING, taken from the shared noc parameters.
- The block has two states, IDLE and LOCKED(owner). owner is a one-hot register.
- A transfer happens when valid_out=1 and credits>0. ack[i]=1 only for the transferring input.
- IDLE state:
  - Candidates are inputs with req_valid & req_match and type HEAD or SING.
  - The arbiter picks one candidate. sel and valid_out assert whenever a candidate exists, even with zero credits.
  - A transferring head moves the block to LOCKED(winner).
  - A transferring single stays in IDLE.
  - shift_ctl = transfer in IDLE.
  - PAYL/TAIL flits arriving in IDLE are ignored: never acked, never selected.
- LOCKED state:
  - sel = owner. valid_out = req_valid[owner]. Other inputs are never acked.
  - Every owner flit is forwarded regardless of type.
  - A transferring TAIL or SING returns the block to IDLE.
  - A non-transfer, whether from no credit or no valid, holds the state.
  - shift_ctl = 0.
- Credit counter:
  - Resets to CREDITS.
  - Transfer only: decrement. credit_in only: increment. Both in the same cycle: unchanged.
  - credit_in at CREDITS is ignored, so the count saturates and never wraps.
  - The counter never underflows, because a transfer requires credits>0.
- Round-robin pointer:
  - One-hot register, reset value bit 0.
  - Search order starts at the pointer and wraps from N_IN-1 to 0.
  - On a transferring head or single from input w, the pointer becomes w+1 mod N_IN.
  - Otherwise the pointer is unchanged, including when a grant is lost for lack of credit.

## Timing
- All outputs are combinational from the inputs and the state registers, giving zero-cycle request-to-ack latency. State updates on the rising clk edge.
- Reset values: state IDLE, owner 0, pointer 1, credits=CREDITS.
- Output values under reset: sel=0, ack=0, valid_out=0, shift_ctl=0, locked=0.
- Reset asserted mid-packet drops the lock immediately and restores full credits. Upstream must be reset together with this block.
- A credit returned in cycle t is usable in cycle t+1.
- sel/valid_out may assert while credits=0. Downstream must qualify valid_out with an ack-derived strobe; upstream must hold its flit until ack.

## Configuration
- NOC_RROBIN_ARB_EN defined: round-robin arbitration using the pointer described above.
- NOC_RROBIN_ARB_EN undefined: fixed priority, lowest index wins. No pointer register is instantiated.
- Lock, credit and state behaviour is identical in both builds.

## Structure
- The shared noc package holds FTYPEWD, the ENC_* flit-type encodings, and a credit-width helper function.
- One natural sub-module: noc_rr_arbiter. It is a combinational N-way round-robin or fixed-priority pick from a request vector and a pointer, with a one-hot grant.
- Credit counter, lock FSM and output muxing stay in the top-level module.

## Test plan
- After reset, input 2 sends HEAD, PAYL, TAIL with credits=4: ack[2] in 3 consecutive cycles, shift_ctl only in the first, locked=1 for 2 cycles, credits ends at 1.
- Inputs 0 and 3 present heads simultaneously, repeated twice, with NOC_RROBIN_ARB_EN defined: 0 wins first, 3 wins second. With the macro undefined, 0 wins both.
- Credits driven to 0 while input 1 is mid-packet: ack=0 and state LOCKED(1) held. credit_in pulse: the next flit is acked one cycle later.
- credit_in together with a transfer at credits=2: credits stays 2. credit_in at credits=4: stays 4.
- While input 4 is locked, input 0 presents a matching head: no ack[0] until input 4's tail transfers, then input 0 is granted the next cycle.
- rst asserted between head and tail: locked=0 and credits=4 asynchronously. A later PAYL on the old owner is ignored.
